// File: rtl/clock_switch_sequencer_pkg.sv
// clk_seq_pkg: shared types and constants for clock_switch_sequencer.
//   state_e          - sequencer FSM states
//   RST_EXT_CLK_SEL  - reset value of the clock-source select (external)
//   RST_SEL/RST_SEL2 - reset values of the core/user divider selects
package clk_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_TO_EXT,
    ST_PROG,
    ST_WAIT_LOCK,
    ST_TO_PLL,
    ST_DONE
  } state_e;

  localparam logic       RST_EXT_CLK_SEL = 1'b1;
  localparam logic [2:0] RST_SEL         = 3'd0;
  localparam logic [2:0] RST_SEL2        = 3'd0;

endpackage

// File: rtl/clock_switch_sequencer_if.sv
// clock_switch_sequencer_if: four-phase configuration request channel.
//   cfg_req         requester -> sequencer  request level
//   cfg_ext_clk_sel requester -> sequencer  target source (1 = external)
//   cfg_sel         requester -> sequencer  target core divider
//   cfg_sel2        requester -> sequencer  target user (90 deg) divider
//   cfg_ack         sequencer -> requester  acknowledge level
//   busy            sequencer -> requester  sequence in progress
interface clock_switch_sequencer_if;
  logic       cfg_req;
  logic       cfg_ext_clk_sel;
  logic [2:0] cfg_sel;
  logic [2:0] cfg_sel2;
  logic       cfg_ack;
  logic       busy;

  modport master (
    output cfg_req, cfg_ext_clk_sel, cfg_sel, cfg_sel2,
    input  cfg_ack, busy
  );

  modport slave (
    input  cfg_req, cfg_ext_clk_sel, cfg_sel, cfg_sel2,
    output cfg_ack, busy
  );
endinterface

// File: rtl/clock_switch_sequencer_sync2.sv
// clk_seq_sync2: two-flop synchronizer with synchronous active-low clear.
//   clk   sampling clock
//   clr_n synchronous clear, active low
//   d     asynchronous input
//   q     synchronized output (2 cycles latency)
module clk_seq_sync2 (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk) begin
    if (!clr_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];
endmodule

// File: rtl/clock_switch_sequencer.sv
// clock_switch_sequencer: glitch-safe clock reconfiguration sequencer.
// Parks the core on the external clock with reset held, reprograms the
// dividers, waits for PLL lock when the PLL is targeted, switches over and
// releases reset. Runs entirely on the external pad clock.
// Ports:
//   ext_clk     sole clock          resetb      sync reset, active low
//   cfg         request channel (slave modport)
//   pll_lock    async PLL lock      ext_clk_sel clock-source select out
//   sel/sel2    divider selects     hold_reset  clocking-block reset hold
//   lock_err    sticky lock failure flag (cleared on request acceptance)
// Build option: CLK_SEQ_LOCK_TIMEOUT_EN bounds WAIT_LOCK to LOCK_TIMEOUT
// cycles; without it WAIT_LOCK waits indefinitely.
module clock_switch_sequencer
  import clk_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1024
) (
  input  logic                      ext_clk,
  input  logic                      resetb,
  clock_switch_sequencer_if.slave   cfg,
  input  logic                      pll_lock,
  output logic                      ext_clk_sel,
  output logic [2:0]                sel,
  output logic [2:0]                sel2,
  output logic                      hold_reset,
  output logic                      lock_err
);

  if (SETTLE_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_bad_param
    $error("SETTLE_CYCLES and LOCK_TIMEOUT must be >= 1");
  end

`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
`else
  localparam int unsigned CNT_MAX = SETTLE_CYCLES;
`endif
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] LOCK_LOAD   = CW'(LOCK_TIMEOUT - 1);
`endif

  logic lock_sync;

  clk_seq_sync2 u_lock_sync (
    .clk   (ext_clk),
    .clr_n (resetb),
    .d     (pll_lock),
    .q     (lock_sync)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          tgt_ext_q, tgt_ext_d;
  logic [2:0]    tgt_sel_q, tgt_sel_d;
  logic [2:0]    tgt_sel2_q, tgt_sel2_d;
  logic          ext_clk_sel_q, ext_clk_sel_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    sel2_q, sel2_d;
  logic          hold_reset_q, hold_reset_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          lock_err_q, lock_err_d;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_zero ? cnt_q : cnt_q - CW'(1);
    start_d       = start_q;
    tgt_ext_d     = tgt_ext_q;
    tgt_sel_d     = tgt_sel_q;
    tgt_sel2_d    = tgt_sel2_q;
    ext_clk_sel_d = ext_clk_sel_q;
    sel_d         = sel_q;
    sel2_d        = sel2_q;
    hold_reset_d  = hold_reset_q;
    ack_d         = ack_q;
    busy_d        = busy_q;
    lock_err_d    = lock_err_q;

    unique case (state_q)
      ST_IDLE: begin
        // Acceptance edge only latches the target; HOLD is entered one edge
        // later so busy/hold_reset rise together on the following edge.
        if (start_q) begin
          start_d      = 1'b0;
          state_d      = ST_HOLD;
          hold_reset_d = 1'b1;
          busy_d       = 1'b1;
          cnt_d        = SETTLE_LOAD;
        end else if (cfg.cfg_req) begin
          start_d    = 1'b1;
          tgt_ext_d  = cfg.cfg_ext_clk_sel;
          tgt_sel_d  = cfg.cfg_sel;
          tgt_sel2_d = cfg.cfg_sel2;
          lock_err_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d       = ST_TO_EXT;
          ext_clk_sel_d = 1'b1;
          cnt_d         = SETTLE_LOAD;
        end
      end
      ST_TO_EXT: begin
        if (cnt_zero) begin
          state_d = ST_PROG;
          sel_d   = tgt_sel_q;
          sel2_d  = tgt_sel2_q;
          cnt_d   = SETTLE_LOAD;
        end
      end
      ST_PROG: begin
        if (cnt_zero) begin
          if (tgt_ext_q) begin
            state_d      = ST_DONE;
            hold_reset_d = 1'b0;
            ack_d        = 1'b1;
          end else begin
            state_d = ST_WAIT_LOCK;
`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
            cnt_d   = LOCK_LOAD;
`endif
          end
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_sync) begin
          state_d       = ST_TO_PLL;
          ext_clk_sel_d = 1'b0;
          cnt_d         = SETTLE_LOAD;
        end
`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
        else if (cnt_zero) begin
          state_d      = ST_DONE;
          lock_err_d   = 1'b1;
          hold_reset_d = 1'b0;
          ack_d        = 1'b1;
        end
`endif
      end
      ST_TO_PLL: begin
        // Lock loss takes priority over normal settle completion.
        if (!lock_sync) begin
          state_d       = ST_DONE;
          ext_clk_sel_d = 1'b1;
          lock_err_d    = 1'b1;
          hold_reset_d  = 1'b0;
          ack_d         = 1'b1;
        end else if (cnt_zero) begin
          state_d      = ST_DONE;
          hold_reset_d = 1'b0;
          ack_d        = 1'b1;
        end
      end
      ST_DONE: begin
        if (!cfg.cfg_req) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ext_clk) begin
    if (!resetb) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      tgt_ext_q     <= RST_EXT_CLK_SEL;
      tgt_sel_q     <= RST_SEL;
      tgt_sel2_q    <= RST_SEL2;
      ext_clk_sel_q <= RST_EXT_CLK_SEL;
      sel_q         <= RST_SEL;
      sel2_q        <= RST_SEL2;
      hold_reset_q  <= 1'b0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      lock_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_q       <= start_d;
      tgt_ext_q     <= tgt_ext_d;
      tgt_sel_q     <= tgt_sel_d;
      tgt_sel2_q    <= tgt_sel2_d;
      ext_clk_sel_q <= ext_clk_sel_d;
      sel_q         <= sel_d;
      sel2_q        <= sel2_d;
      hold_reset_q  <= hold_reset_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      lock_err_q    <= lock_err_d;
    end
  end

  assign cfg.cfg_ack  = ack_q;
  assign cfg.busy     = busy_q;
  assign ext_clk_sel  = ext_clk_sel_q;
  assign sel          = sel_q;
  assign sel2         = sel2_q;
  assign hold_reset   = hold_reset_q;
  assign lock_err     = lock_err_q;

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// tb_clock_switch_sequencer: randomized bench for clock_switch_sequencer.
// Expected outputs are derived per edge from the sequence timeline
// (edge numbers of HOLD/PROG/TO_PLL/DONE entry) computed arithmetically
// from the request, the driven pll_lock waveform and the handshake.
// Honors CLK_SEQ_LOCK_TIMEOUT_EN for the timeout scenario.
module tb_clock_switch_sequencer;

  localparam int S  = 4;
  localparam int LT = 32;
  localparam int NEVER = 1000000;

  logic       ext_clk = 1'b0;
  logic       resetb  = 1'b0;
  logic       pll_lock = 1'b0;
  logic       ext_clk_sel;
  logic [2:0] sel, sel2;
  logic       hold_reset, lock_err;

  clock_switch_sequencer_if csi ();

  clock_switch_sequencer #(
    .SETTLE_CYCLES (S),
    .LOCK_TIMEOUT  (LT)
  ) u_dut (
    .ext_clk     (ext_clk),
    .resetb      (resetb),
    .cfg         (csi.slave),
    .pll_lock    (pll_lock),
    .ext_clk_sel (ext_clk_sel),
    .sel         (sel),
    .sel2        (sel2),
    .hold_reset  (hold_reset),
    .lock_err    (lock_err)
  );

  always #5 ext_clk = ~ext_clk;

  int checks = 0;
  int errors = 0;

  // Model of the externally visible configuration between sequences.
  logic       m_ext  = 1'b1;
  logic [2:0] m_sel  = 3'd0;
  logic [2:0] m_sel2 = 3'd0;
  logic       m_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic b, input logic a, input logic h,
                                       input logic e, input logic [2:0] s,
                                       input logic [2:0] s2, input logic r);
    return {21'b0, b, a, h, e, s, s2, r};
  endfunction

  function automatic logic [31:0] observed();
    return pack(csi.busy, csi.cfg_ack, hold_reset, ext_clk_sel, sel, sel2, lock_err);
  endfunction

  // Raw pll_lock level sampled at edge k of a transaction.
  function automatic logic raw_lock(input int k, input int r, input int d);
    return (k >= r) && (k < d);
  endfunction

  // One complete request. Edge 0 is the edge sampling cfg_req=1 in IDLE.
  task automatic run_txn(input string tag, input logic t_ext, input logic [2:0] ts,
                         input logic [2:0] ts2, input int r, input int d,
                         input int h, input logic viol);
    int   w, p, a, f;
    logic err, fin;
    logic exp_e;
    string t;
    w = 3 * S + 1;
    p = -1;
    a = -1;
    err = 1'b0;
    fin = 1'b1;
    if (t_ext) begin
      a = w;
    end else begin
      // The FSM sees the raw lock of two edges earlier.
      for (int n = w + 1; n <= w + LT + 200; n++) begin
        if (raw_lock(n - 2, r, d)) begin p = n; break; end
`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
        if (n == w + LT) begin a = n; err = 1'b1; break; end
`endif
      end
      if (p >= 0) begin
        a = p + S;
        fin = 1'b0;
        for (int n = p + 1; n <= p + S; n++) begin
          if (!raw_lock(n - 2, r, d)) begin a = n; err = 1'b1; fin = 1'b1; break; end
        end
      end
      if (a < 0) a = w + LT + 200;
    end
    f = viol ? a + 1 : a + h + 1;

    csi.cfg_req         = 1'b1;
    csi.cfg_ext_clk_sel = t_ext;
    csi.cfg_sel         = ts;
    csi.cfg_sel2        = ts2;
    pll_lock            = raw_lock(0, r, d);
    @(posedge ext_clk); #1;
    for (int n = 0; n <= f + 2; n++) begin
      if (n <= S)                          exp_e = m_ext;
      else if (p >= 0 && n >= p && n < a)  exp_e = 1'b0;
      else if (n >= a)                     exp_e = fin;
      else                                 exp_e = 1'b1;
      t = $sformatf("%s_e%0d", tag, n);
      check_eq(t, observed(),
               pack(n >= 1 && n < f, n >= a && n < f, n >= 1 && n < a, exp_e,
                    (n < 2 * S + 1) ? m_sel : ts, (n < 2 * S + 1) ? m_sel2 : ts2,
                    (n < a) ? 1'b0 : err));
      // Later cfg changes must be ignored.
      csi.cfg_ext_clk_sel = 1'($urandom);
      csi.cfg_sel         = 3'($urandom);
      csi.cfg_sel2        = 3'($urandom);
      pll_lock            = raw_lock(n + 1, r, d);
      csi.cfg_req         = viol ? (n + 1 <= 3) : (n + 1 <= a + h);
      @(posedge ext_clk); #1;
    end
    m_ext  = fin;
    m_sel  = ts;
    m_sel2 = ts2;
    m_err  = err;
  endtask

  initial begin
    int w, r, d, p, h;
    logic t_ext, viol;
    csi.cfg_req = 1'b0;
    csi.cfg_ext_clk_sel = 1'b1;
    csi.cfg_sel = 3'd0;
    csi.cfg_sel2 = 3'd0;
    w = 3 * S + 1;

    repeat (3) @(posedge ext_clk);
    #1;
    check_eq("reset", observed(), pack(0, 0, 0, 1, 3'd0, 3'd0, 0));
    resetb = 1'b1;
    @(posedge ext_clk); #1;
    check_eq("idle", observed(), pack(0, 0, 0, 1, 3'd0, 3'd0, 0));

    run_txn("ext35",  1'b1, 3'd3, 3'd5, NEVER, NEVER, 5, 1'b0);
    run_txn("pll2",   1'b0, 3'd2, 3'd1, -100, NEVER, 0, 1'b0);
    run_txn("lossto", 1'b0, 3'd6, 3'd7, -100, w + 1 + 2, 1, 1'b0);
    run_txn("late",   1'b0, 3'd1, 3'd4, w + 5, NEVER, 2, 1'b0);
    run_txn("viol",   1'b1, 3'd7, 3'd2, NEVER, NEVER, 0, 1'b1);
`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
    run_txn("tmo",    1'b0, 3'd5, 3'd3, NEVER, NEVER, 1, 1'b0);
`endif

    // Reset while in PROG: outputs return to reset values, no ack.
    csi.cfg_req = 1'b1;
    csi.cfg_ext_clk_sel = 1'b0;
    csi.cfg_sel = 3'd6;
    csi.cfg_sel2 = 3'd5;
    pll_lock = 1'b1;
    @(posedge ext_clk); #1;
    repeat (2 * S + 2) @(posedge ext_clk);
    #1;
    check_eq("prog_sel", {29'b0, sel}, 32'd6);
    resetb = 1'b0;
    @(posedge ext_clk); #1;
    check_eq("rst_prog", observed(), pack(0, 0, 0, 1, 3'd0, 3'd0, 0));
    resetb = 1'b1;
    csi.cfg_req = 1'b0;
    repeat (3) @(posedge ext_clk);
    #1;
    check_eq("rst_after", observed(), pack(0, 0, 0, 1, 3'd0, 3'd0, 0));
    m_ext = 1'b1; m_sel = 3'd0; m_sel2 = 3'd0; m_err = 1'b0;

    for (int i = 0; i < 25; i++) begin
      t_ext = 1'($urandom);
      r = w - 3 + int'($urandom % 20);
      d = NEVER;
      p = (r + 2 > w + 1) ? r + 2 : w + 1;
      if ($urandom % 2 == 0) d = p + 1 + int'($urandom % (S - 1));
`ifdef CLK_SEQ_LOCK_TIMEOUT_EN
      if ($urandom % 5 == 0) begin r = NEVER; d = NEVER; end
`endif
      h = int'($urandom % 7);
      viol = ($urandom % 8 == 0);
      run_txn($sformatf("rnd%0d", i), t_ext, 3'($urandom), 3'($urandom), r, d, h, viol);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
